// File: rtl/mem_stage.sv
// Pipeline MEM stage: word-addressed data memory with configurable access latency,
// a stall FSM that freezes upstream during multi-cycle accesses, and the MEM/WB register.
module mem_stage #(
  parameter int DEPTH_WORDS = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        err_addr
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } req_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  req_t            lat_q, lat_d;
  req_t            ex_req, cur;
  logic            complete, mem_op, illegal, mem_we;
  logic [IW-1:0]   idx;
  logic [31:0]     rdata;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            err_q, err_d;

  always_comb begin
    ex_req = '{alu: ex_alu_result, sd: ex_store_data, rd: ex_rd, rw: ex_reg_write,
               mr: ex_mem_read, mw: ex_mem_write, m2r: ex_mem_to_reg};
  end

  // In BUSY the upstream copy is ignored; the latched request drives everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    complete = 1'b0;
    cur      = (state_q == BUSY) ? lat_q : ex_req;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if ((ex_mem_read || ex_mem_write) && (MEM_LATENCY > 1)) begin
            state_d = BUSY;
            cnt_d   = CW'(MEM_LATENCY - 2);
            lat_d   = ex_req;
          end else begin
            complete = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_op  = cur.mr | cur.mw;
    illegal = mem_op & ((cur.alu[1:0] != 2'b00) | (cur.mr & cur.mw));
    idx     = cur.alu[IW+1:2];
    rdata   = mem[idx];
    // Gate with reset so an access completing under reset never lands in memory.
    mem_we  = complete & cur.mw & ~illegal & ~reset;

    wb_valid_d     = complete;
    wb_reg_write_d = complete & cur.rw & ~illegal;
    err_d          = complete & illegal;
    wb_rd_d        = complete ? cur.rd : wb_rd_q;
    wb_data_d      = complete ? (cur.m2r ? rdata : cur.alu) : wb_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      lat_q          <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lat_q          <= lat_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_data_q      <= wb_data_d;
      err_q          <= err_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= cur.sd;
  end

  assign stall        = (state_q == BUSY);
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_data      = wb_data_q;
  assign err_addr     = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset-in-flight sequence, random ops
// against a word-array reference model, and a latency-3 back-to-back sequence.
module tb_mem_stage;

  localparam int DEPTH = 64;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r;
  } op_t;

  typedef struct {
    op_t         op;
    logic        chk;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid, a_rw, a_mr, a_mw, a_m2r;
  logic [31:0] a_alu, a_sd;
  logic [4:0]  a_rd;
  logic        a_stall, a_wbv, a_wbrw, a_err;
  logic [4:0]  a_wbrd;
  logic [31:0] a_wbd;

  logic        b_valid, b_rw, b_mr, b_mw, b_m2r;
  logic [31:0] b_alu, b_sd;
  logic [4:0]  b_rd;
  logic        b_stall, b_wbv, b_wbrw, b_err;
  logic [4:0]  b_wbrd;
  logic [31:0] b_wbd;

  mem_stage #(.DEPTH_WORDS(DEPTH), .MEM_LATENCY(2)) u_dut (
    .clk(clk), .reset(rst), .ex_valid(a_valid), .ex_alu_result(a_alu),
    .ex_store_data(a_sd), .ex_rd(a_rd), .ex_reg_write(a_rw), .ex_mem_read(a_mr),
    .ex_mem_write(a_mw), .ex_mem_to_reg(a_m2r), .stall(a_stall), .wb_valid(a_wbv),
    .wb_rd(a_wbrd), .wb_reg_write(a_wbrw), .wb_data(a_wbd), .err_addr(a_err));

  mem_stage #(.DEPTH_WORDS(DEPTH), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(rst), .ex_valid(b_valid), .ex_alu_result(b_alu),
    .ex_store_data(b_sd), .ex_rd(b_rd), .ex_reg_write(b_rw), .ex_mem_read(b_mr),
    .ex_mem_write(b_mw), .ex_mem_to_reg(b_m2r), .stall(b_stall), .wb_valid(b_wbv),
    .wb_rd(b_wbrd), .wb_reg_write(b_wbrw), .wb_data(b_wbd), .err_addr(b_err));

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_m [DEPTH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  function automatic op_t mk_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic mw, input logic m2r);
    op_t o;
    o.alu = alu; o.sd = sd; o.rd = rd; o.rw = rw; o.mr = mr; o.mw = mw; o.m2r = m2r;
    return o;
  endfunction

  function automatic vec_t mk_vec(input op_t o, input logic chk, input logic [31:0] d,
                                  input logic rw, input logic err);
    vec_t v;
    v.op = o; v.chk = chk; v.exp_data = d; v.exp_rw = rw; v.exp_err = err;
    return v;
  endfunction

  // Reference: memory as a plain word array, addresses reduced arithmetically.
  task automatic model_step(input op_t o, output logic [31:0] d, output logic rw, output logic err);
    int unsigned idx;
    logic ill;
    idx = (o.alu / 4) % DEPTH;
    ill = (o.mr || o.mw) && (((o.alu % 4) != 0) || (o.mr && o.mw));
    d   = o.m2r ? mem_m[idx] : o.alu;
    rw  = o.rw && !ill;
    err = ill;
    if (o.mw && !ill) mem_m[idx] = o.sd;
  endtask

  task automatic drive_a(input op_t o);
    a_valid = 1'b1; a_alu = o.alu; a_sd = o.sd; a_rd = o.rd;
    a_rw = o.rw; a_mr = o.mr; a_mw = o.mw; a_m2r = o.m2r;
  endtask

  task automatic run_op(input op_t o, input logic chk, input logic [31:0] exp_d,
                        input logic exp_rw, input logic exp_err);
    int lat;
    lat = (o.mr || o.mw) ? 2 : 1;
    @(negedge clk);
    drive_a(o);
    check("idle_stall", {31'b0, a_stall}, 32'd0);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c < lat) begin
        check("busy_stall", {31'b0, a_stall}, 32'd1);
        check("busy_wb_valid", {31'b0, a_wbv}, 32'd0);
        check("busy_err", {31'b0, a_err}, 32'd0);
        // Upstream values during BUSY must not matter.
        a_valid = 1'($urandom()); a_alu = $urandom(); a_sd = $urandom(); a_rd = 5'($urandom());
        a_rw = 1'($urandom()); a_mr = 1'($urandom()); a_mw = 1'($urandom()); a_m2r = 1'($urandom());
      end else begin
        check("done_stall", {31'b0, a_stall}, 32'd0);
        check("done_wb_valid", {31'b0, a_wbv}, 32'd1);
        check("done_wb_rd", {27'b0, a_wbrd}, {27'b0, o.rd});
        check("done_wb_rw", {31'b0, a_wbrw}, {31'b0, exp_rw});
        check("done_err", {31'b0, a_err}, {31'b0, exp_err});
        if (chk) check("done_wb_data", a_wbd, exp_d);
        a_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("bubble_wb_valid", {31'b0, a_wbv}, 32'd0);
    check("bubble_wb_rw", {31'b0, a_wbrw}, 32'd0);
    check("bubble_err", {31'b0, a_err}, 32'd0);
    if (chk) check("bubble_wb_data_hold", a_wbd, exp_d);
  endtask

  task automatic model_run(input op_t o);
    logic [31:0] d;
    logic rw, err;
    model_step(o, d, rw, err);
    run_op(o, 1'b1, d, rw, err);
  endtask

  vec_t tbl[12];

  initial begin
    op_t o;
    logic [31:0] d;
    logic rw, err;
    op_t bops[4];
    logic [31:0] bexp[4];

    a_valid = 0; a_alu = 0; a_sd = 0; a_rd = 0; a_rw = 0; a_mr = 0; a_mw = 0; a_m2r = 0;
    b_valid = 0; b_alu = 0; b_sd = 0; b_rd = 0; b_rw = 0; b_mr = 0; b_mw = 0; b_m2r = 0;

    #12;
    check("rst_stall", {31'b0, a_stall}, 32'd0);
    check("rst_wb_valid", {31'b0, a_wbv}, 32'd0);
    check("rst_wb_data", a_wbd, 32'd0);
    check("rst_wb_rd", {27'b0, a_wbrd}, 32'd0);
    check("rst_wb_rw", {31'b0, a_wbrw}, 32'd0);
    check("rst_err", {31'b0, a_err}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Known contents everywhere; upper address bits exercise wrap.
    for (int i = 0; i < DEPTH; i++) begin
      o = mk_op((($urandom() << 8) | 32'(i * 4)), 32'hA500_0000 | 32'(i), 5'(i), 1'b0, 1'b0, 1'b1, 1'b0);
      model_run(o);
    end

    tbl[0]  = mk_vec(mk_op(32'h0000_002A, 32'h0, 5'd3, 1, 0, 0, 0), 1, 32'h0000_002A, 1, 0);
    tbl[1]  = mk_vec(mk_op(32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 0, 0, 1, 0), 1, 32'h0000_0010, 0, 0);
    tbl[2]  = mk_vec(mk_op(32'h0000_0010, 32'h0, 5'd5, 1, 1, 0, 1), 1, 32'hDEAD_BEEF, 1, 0);
    tbl[3]  = mk_vec(mk_op(32'h0000_0104, 32'h1111_1111, 5'd0, 0, 0, 1, 0), 1, 32'h0000_0104, 0, 0);
    tbl[4]  = mk_vec(mk_op(32'h0000_0004, 32'h0, 5'd6, 1, 1, 0, 1), 1, 32'h1111_1111, 1, 0);
    tbl[5]  = mk_vec(mk_op(32'h0000_0013, 32'h0, 5'd7, 1, 1, 0, 1), 0, 32'h0, 0, 1);
    tbl[6]  = mk_vec(mk_op(32'h0000_0010, 32'h0, 5'd8, 1, 1, 0, 1), 1, 32'hDEAD_BEEF, 1, 0);
    tbl[7]  = mk_vec(mk_op(32'h0000_0020, 32'hBADB_AD00, 5'd4, 1, 1, 1, 0), 1, 32'h0000_0020, 0, 1);
    tbl[8]  = mk_vec(mk_op(32'h0000_0020, 32'h0, 5'd9, 1, 1, 0, 1), 1, 32'hA500_0008, 1, 0);
    tbl[9]  = mk_vec(mk_op(32'h0000_0022, 32'h5555_5555, 5'd2, 0, 0, 1, 0), 1, 32'h0000_0022, 0, 1);
    tbl[10] = mk_vec(mk_op(32'h0000_0020, 32'h0, 5'd12, 1, 1, 0, 1), 1, 32'hA500_0008, 1, 0);
    tbl[11] = mk_vec(mk_op(32'hFFFF_FF10, 32'h0, 5'd10, 1, 1, 0, 1), 1, 32'hDEAD_BEEF, 1, 0);
    for (int i = 0; i < 12; i++) begin
      model_step(tbl[i].op, d, rw, err);
      run_op(tbl[i].op, tbl[i].chk, tbl[i].exp_data, tbl[i].exp_rw, tbl[i].exp_err);
    end

    // Reset while a store is in flight: dropped, memory keeps old word.
    @(negedge clk);
    drive_a(mk_op(32'h0000_0040, 32'h1234_5678, 5'd1, 0, 0, 1, 0));
    @(posedge clk); #1;
    check("rstmid_busy_stall", {31'b0, a_stall}, 32'd1);
    rst = 1'b1; #1;
    check("rstmid_stall", {31'b0, a_stall}, 32'd0);
    check("rstmid_wb_valid", {31'b0, a_wbv}, 32'd0);
    check("rstmid_wb_data", a_wbd, 32'd0);
    check("rstmid_wb_rd", {27'b0, a_wbrd}, 32'd0);
    check("rstmid_err", {31'b0, a_err}, 32'd0);
    a_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    run_op(mk_op(32'h0000_0040, 32'h0, 5'd11, 1, 1, 0, 1), 1, 32'hA500_0010, 1, 0);

    for (int n = 0; n < 300; n++) begin
      o = mk_op($urandom(), $urandom(), 5'($urandom()), 1'($urandom()), 0, 0, 0);
      case ($urandom_range(0, 3))
        0: ;
        1: begin o.alu[1:0] = 2'b00; o.mr = 1; o.m2r = 1; end
        2: begin o.alu[1:0] = 2'b00; o.mw = 1; end
        default: begin
          if ($urandom_range(0, 1) == 0) begin o.mr = 1; o.mw = 1; end
          else begin
            o.alu[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) o.mr = 1; else o.mw = 1;
          end
        end
      endcase
      model_run(o);
    end

    // Latency 3, back-to-back: wb_valid 0,0,1 per op with ex_valid held high.
    bops[0] = mk_op(32'h0000_0000, 32'hCAFE_F00D, 5'd0, 0, 0, 1, 0); bexp[0] = 32'h0000_0000;
    bops[1] = mk_op(32'h0000_0004, 32'h0BAD_F00D, 5'd0, 0, 0, 1, 0); bexp[1] = 32'h0000_0004;
    bops[2] = mk_op(32'h0000_0000, 32'h0, 5'd1, 1, 1, 0, 1);        bexp[2] = 32'hCAFE_F00D;
    bops[3] = mk_op(32'h0000_0104, 32'h0, 5'd2, 1, 1, 0, 1);        bexp[3] = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b_valid = 1; b_alu = bops[k].alu; b_sd = bops[k].sd; b_rd = bops[k].rd;
      b_rw = bops[k].rw; b_mr = bops[k].mr; b_mw = bops[k].mw; b_m2r = bops[k].m2r;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check("l3_wb_valid", {31'b0, b_wbv}, (c == 2) ? 32'd1 : 32'd0);
        check("l3_stall", {31'b0, b_stall}, (c == 2) ? 32'd0 : 32'd1);
      end
      check("l3_wb_data", b_wbd, bexp[k]);
      check("l3_wb_rw", {31'b0, b_wbrw}, {31'b0, bops[k].rw});
    end
    b_valid = 0;
    @(posedge clk); #1;
    check("l3_tail_wb_valid", {31'b0, b_wbv}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage fed directly by the EX/MEM register; consumes the ALU result (address) and forwarded store data produced by the execute stage.
- Contains word-addressed data memory with configurable access latency, a small FSM that stalls the upstream pipeline during multi-cycle accesses, and the MEM/WB output register.
- Its writeback value is the mem_wb_fwd source for execute-stage forwarding.

Parameters:
- DEPTH_WORDS, 64, data memory size in 32-bit words; power of two, >= 4.
- MEM_LATENCY, 2, cycles per load/store from acceptance to MEM/WB update; >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- ex_valid  input  1  EX/MEM holds a valid instruction
- ex_alu_result  input  32  ALU result; byte address for loads/stores
- ex_store_data  input  32  forwarded store data (execute-stage data2 after forwarding)
- ex_rd  input  5  destination register
- ex_reg_write  input  1  instruction writes the register file
- ex_mem_read  input  1  load
- ex_mem_write  input  1  store
- ex_mem_to_reg  input  1  writeback selects memory data
- stall  output  1  upstream must hold EX/MEM and earlier stages
- wb_valid  output  1  MEM/WB holds a valid instruction
- wb_rd  output  5  registered destination
- wb_reg_write  output  1  registered write enable, already qualified
- wb_data  output  32  writeback value; also mem_wb_fwd
- err_addr  output  1  one-cycle pulse: misaligned or illegal access retired

Behaviour:
- Reset (async): state IDLE, counter 0, all outputs 0. Memory array is not cleared. Any in-flight access is dropped, including a pending store; memory is unmodified.
- FSM states: IDLE, BUSY.
- Memory op: ex_mem_read or ex_mem_write.
- Accepted: ex_valid in IDLE.
  - Non-memory op: next edge loads MEM/WB with wb_data = ex_alu_result. Latency is 1, state stays IDLE.
  - Memory op with MEM_LATENCY = 1: completes at the next edge like a non-memory op.
  - Memory op with MEM_LATENCY > 1: at the accepting edge, latch all ex_* fields and go to BUSY with counter = MEM_LATENCY-2.
- BUSY:
  - stall = 1 combinationally.
  - wb_valid = 0 on every edge in BUSY except the completing one; the bubble suppresses writeback.
  - ex_* inputs are ignored; upstream holds them.
  - When the counter is 0, the edge completes the access: MEM/WB is loaded and state returns to IDLE. Otherwise the counter decrements.
- stall = 0 in IDLE; after completion the held instruction is accepted on the following edge.
- ex_valid = 0 in IDLE: next edge writes a bubble (wb_valid = 0, wb_reg_write = 0, wb_data unchanged).
- Address decode:
  - index = addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - addr[1:0] != 0 is misaligned.
- Store: memory[index] <= latched store data on the completing edge only.
- Load:
  - Read data is memory[index] sampled at the completing edge.
  - A load immediately after a store to the same index returns the new data.
- wb_data = mem_to_reg ? read data : alu_result.
- Illegal access (misaligned, or ex_mem_read and ex_mem_write both 1):
  - Full latency is still taken.
  - No memory write; wb_reg_write forced 0; wb_valid = 1.
  - err_addr = 1 for exactly the completing cycle.
- wb_reg_write = ex_reg_write AND valid AND NOT illegal.
- wb_rd is registered unconditionally with the instruction.

Test Plan:
- MEM_LATENCY=2: store 0xDEADBEEF to addr 0x10, then load from 0x10 with mem_to_reg=1, rd=5 -> stall high one cycle per op; load completes with wb_data=0xDEADBEEF, wb_rd=5, wb_reg_write=1.
- Non-memory op with alu_result=0x0000002A, rd=3, reg_write=1 -> next cycle wb_valid=1, wb_data=0x2A, stall never asserted.
- Store 0x11111111 to addr 0x104 (DEPTH_WORDS=64), then load 0x004 -> returns 0x11111111 (wrap).
- Load from addr 0x13 -> err_addr pulses once, wb_reg_write=0, memory unchanged; read and write both 1 at 0x20 -> same error response, word 8 unchanged.
- Assert reset mid-BUSY of a store of 0x12345678 to 0x40 -> outputs 0 immediately, state IDLE; subsequent load of 0x40 returns the prior contents.
- MEM_LATENCY=3, back-to-back loads -> stall high 2 cycles each; wb_valid pattern 0,0,1,0,0,1.
